// File: rtl/ramb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ramb_stream_reader
// Brief    : Walks a wrapping RAM address range and streams each word out
//            over valid/ready, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module ramb_stream_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_do,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W:0]     r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W:0]     w_len_sat;
    logic                w_last;

    // Counts beyond the RAM depth collapse to one full pass of the RAM.
    assign w_len_sat = (len > c_DEPTH) ? c_DEPTH : len;
    assign w_last    = (r_idx == (r_remaining - c_CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base;
                        r_remaining <= w_len_sat;
                        r_idx       <= '0;
                        if (w_len_sat == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_data  <= ram_do;
                    r_valid <= 1'b1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + c_CNT_ONE;
                            r_addr  <= r_addr + c_ADR_ONE;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_a     = r_addr;
    assign ram_we    = 1'b0;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
